hazard_control_unit: RTL and testbench

Pipeline control block that drives the per-stage enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC write enable. It resolves memory stalls, load-use hazards, taken-branch/jump redirects, fetch misses and halt. It also keeps saturating performance counters. It sits beside the datapath and consumes decoded status from the pipeline register outputs and the cache hit lines. Register semantics are: EN=1, FLUSH=0 loads; EN=1, FLUSH=1 clears; EN=0 holds.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_control_unit.sv | 119 +++++++++++
 tb/tb_hazard_control_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU pipeline types and constants
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stage enable/flush and PC write control
// Resolves memory stalls, load-use, redirects, fetch misses and halt.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int STALL_W = 32,
  parameter int FLUSH_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               mem_req,
  input  logic               idex_dREN,
  input  logic [4:0]         idex_rt,
  input  logic [4:0]         ifid_rs,
  input  logic [4:0]         ifid_rt,
  input  logic               ifid_uses_rt,
  input  logic               branch_taken,
  input  logic               halt_in,
  output logic               pc_EN,
  output logic               IF_EN,
  output logic               ID_EN,
  output logic               EX_EN,
  output logic               MEM_EN,
  output logic               IF_FLUSH,
  output logic               ID_FLUSH,
  output logic               EX_FLUSH,
  output logic               MEM_FLUSH,
  output logic               halt,
  output logic [STALL_W-1:0] stall_count,
  output logic [FLUSH_W-1:0] flush_count
);

  hazard_state_t state_q, state_d;
  logic          ihit_pend_q, ihit_pend_d;
  logic          fetch_ok, dstall, load_use;
  logic          stall_inc, flush_inc;

  assign fetch_ok = ihit | ihit_pend_q;
  assign dstall   = mem_req & ~dhit;
  assign load_use = idex_dREN & (idex_rt != REG_ZERO) &
                    ((ifid_rs == idex_rt) | (ifid_uses_rt & (ifid_rt == idex_rt)));

  always_comb begin
    pc_EN       = 1'b0;
    IF_EN       = 1'b0;
    ID_EN       = 1'b0;
    EX_EN       = 1'b0;
    MEM_EN      = 1'b0;
    IF_FLUSH    = 1'b0;
    ID_FLUSH    = 1'b0;
    EX_FLUSH    = 1'b0;
    MEM_FLUSH   = 1'b0;
    halt        = 1'b0;
    state_d     = state_q;
    ihit_pend_d = ihit_pend_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (RST) begin
      state_d     = RUN;
      ihit_pend_d = 1'b0;
    end else if (state_q == HALT) begin
      halt = 1'b1;
    end else begin
      // DWAIT and RUN share every output decision; state only records the wait.
      state_d = RUN;
      if (dstall) begin
        state_d = DWAIT;
      end else if (halt_in) begin
        {IF_EN, ID_EN, EX_EN, MEM_EN} = 4'b1111;
        {IF_FLUSH, ID_FLUSH, EX_FLUSH} = 3'b111;
        state_d = HALT;
      end else if (branch_taken) begin
        {IF_EN, ID_EN, EX_EN, MEM_EN} = 4'b1111;
        {IF_FLUSH, ID_FLUSH, EX_FLUSH} = 3'b111;
        pc_EN     = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        {ID_EN, EX_EN, MEM_EN} = 3'b111;
        ID_FLUSH = 1'b1;
      end else if (!fetch_ok) begin
        {IF_EN, ID_EN, EX_EN, MEM_EN} = 4'b1111;
        IF_FLUSH = 1'b1;
      end else begin
        {IF_EN, ID_EN, EX_EN, MEM_EN} = 4'b1111;
        pc_EN = 1'b1;
      end
      // A fetch that lands while the PC is frozen is remembered until the PC moves.
      ihit_pend_d = pc_EN ? 1'b0 : (ihit_pend_q | ihit);
      stall_inc   = ~pc_EN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      ihit_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ihit_pend_q <= ihit_pend_d;
    end
  end

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(FLUSH_W)) u_flush_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed plus random bench for hazard_control_unit
module tb_hazard_control_unit;

  typedef enum int {HOLD, LOAD, CLEAR} act_t;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, mem_req, idex_dREN, ifid_uses_rt, branch_taken, halt_in;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic pc_EN, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, halt;
  logic [31:0] stall_count;
  logic [15:0] flush_count;
  logic s_pc_EN, s_IF_EN, s_ID_EN, s_EX_EN, s_MEM_EN;
  logic s_IF_FLUSH, s_ID_FLUSH, s_EX_FLUSH, s_MEM_FLUSH, s_halt;
  logic [3:0] s_stall_count;
  logic [1:0] s_flush_count;

  int errors = 0;
  int checks = 0;

  bit          m_halted, m_pend;
  longint      m_stall, m_flush, m_sstall, m_sflush;

  always #5 CLK = ~CLK;

  hazard_control_unit u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .halt_in(halt_in),
    .pc_EN(pc_EN), .IF_EN(IF_EN), .ID_EN(ID_EN), .EX_EN(EX_EN), .MEM_EN(MEM_EN),
    .IF_FLUSH(IF_FLUSH), .ID_FLUSH(ID_FLUSH), .EX_FLUSH(EX_FLUSH), .MEM_FLUSH(MEM_FLUSH),
    .halt(halt), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_control_unit #(.STALL_W(4), .FLUSH_W(2)) u_small (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .halt_in(halt_in),
    .pc_EN(s_pc_EN), .IF_EN(s_IF_EN), .ID_EN(s_ID_EN), .EX_EN(s_EX_EN), .MEM_EN(s_MEM_EN),
    .IF_FLUSH(s_IF_FLUSH), .ID_FLUSH(s_ID_FLUSH), .EX_FLUSH(s_EX_FLUSH),
    .MEM_FLUSH(s_MEM_FLUSH), .halt(s_halt), .stall_count(s_stall_count),
    .flush_count(s_flush_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit ih, input bit dh, input bit mr,
                       input bit dren, input int rt_ex, input int rs, input int rt,
                       input bit uses, input bit br, input bit hl);
    RST = rst; ihit = ih; dhit = dh; mem_req = mr; idex_dREN = dren;
    idex_rt = 5'(rt_ex); ifid_rs = 5'(rs); ifid_rt = 5'(rt);
    ifid_uses_rt = uses; branch_taken = br; halt_in = hl;
  endtask

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Reference: decide what each stage register does this cycle, then derive EN/FLUSH.
  task automatic cyc(input string tag);
    act_t a [4];
    bit pc, hz, br_taken, dep, nxt_halted, nxt_pend;
    logic [9:0] exp_v, obs_v, sobs_v;
    #1;
    pc = 0; br_taken = 0; nxt_halted = m_halted; nxt_pend = m_pend;
    foreach (a[i]) a[i] = HOLD;
    dep = idex_dREN && idex_rt != 0 &&
          (ifid_rs == idex_rt || (ifid_uses_rt && ifid_rt == idex_rt));
    if (RST || m_halted) begin
      pc = 0;
    end else if (mem_req && !dhit) begin
      pc = 0;
    end else if (halt_in) begin
      a = '{CLEAR, CLEAR, CLEAR, LOAD}; nxt_halted = 1;
    end else if (branch_taken) begin
      a = '{CLEAR, CLEAR, CLEAR, LOAD}; pc = 1; br_taken = 1;
    end else if (dep) begin
      a = '{HOLD, CLEAR, LOAD, LOAD};
    end else if (!(ihit || m_pend)) begin
      a = '{CLEAR, LOAD, LOAD, LOAD};
    end else begin
      a = '{LOAD, LOAD, LOAD, LOAD}; pc = 1;
    end
    hz = m_halted && !RST;
    exp_v = {pc, a[0] != HOLD, a[1] != HOLD, a[2] != HOLD, a[3] != HOLD,
             a[0] == CLEAR, a[1] == CLEAR, a[2] == CLEAR, a[3] == CLEAR, hz};
    obs_v = {pc_EN, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH, halt};
    sobs_v = {s_pc_EN, s_IF_EN, s_ID_EN, s_EX_EN, s_MEM_EN,
              s_IF_FLUSH, s_ID_FLUSH, s_EX_FLUSH, s_MEM_FLUSH, s_halt};
    check({tag, ".outs"}, 64'(obs_v), 64'(exp_v));
    check({tag, ".small_outs"}, 64'(sobs_v), 64'(exp_v));
    check({tag, ".stall_count"}, 64'(stall_count), 64'(m_stall));
    check({tag, ".flush_count"}, 64'(flush_count), 64'(m_flush));
    check({tag, ".small_stall"}, 64'(s_stall_count), 64'(m_sstall));
    check({tag, ".small_flush"}, 64'(s_flush_count), 64'(m_sflush));
    @(posedge CLK);
    if (RST) begin
      m_halted = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
    end else if (!m_halted) begin
      if (ihit && !pc) nxt_pend = 1;
      if (pc) nxt_pend = 0;
      if (!pc) begin
        m_stall  = sat_inc(m_stall, 64'hFFFF_FFFF);
        m_sstall = sat_inc(m_sstall, 15);
      end
      if (br_taken) begin
        m_flush  = sat_inc(m_flush, 16'hFFFF);
        m_sflush = sat_inc(m_sflush, 3);
      end
      m_halted = nxt_halted; m_pend = nxt_pend;
    end
    @(negedge CLK);
  endtask

  initial begin
    m_halted = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    cyc("reset0");
    cyc("reset1");

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0); cyc("run");
    end
    check("run.stall_zero", 64'(stall_count), 64'd0);

    drive(0, 1, 0, 0, 1, 5, 5, 0, 0, 0, 0); cyc("loaduse_rs");
    drive(0, 1, 0, 0, 0, 5, 5, 0, 0, 0, 0); cyc("loaduse_after");
    check("loaduse.stall_one", 64'(stall_count), 64'd1);
    drive(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0); cyc("loaduse_r0");
    drive(0, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0); cyc("loaduse_rt_noihit");
    drive(0, 1, 0, 0, 1, 7, 3, 7, 0, 0, 0); cyc("rt_unused");

    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dstall1");
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dstall2_ihit");
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dstall3");
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dhit_pending_fetch");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("fetch_miss");

    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("branch");
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0); cyc("branch_dstall1");
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0); cyc("branch_dstall2");
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0); cyc("branch_dhit");
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dhit_ihit_same");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("branch_sat");
    end

    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("stall_sat");
    end
    check("small_stall_sat", 64'(s_stall_count), 64'd15);

    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("halt_in");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("halted1");
    drive(0, 1, 1, 1, 1, 4, 4, 0, 0, 0, 1); cyc("halted2");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("halt_reset");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("after_reset");

    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dwait_pre_reset");
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("dwait_reset");

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0), $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) != 0, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
